// File: rtl/pipe_stage_buf.sv
// Elastic pipeline segment buffer: DEPTH-entry FIFO carrying {data, ctrl} under valid/ready.
// Side-effect ctrl bits read as zero whenever no entry is valid, so bubbles never commit state.
module pipe_stage_buf #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CTRL_W = 5,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [CTRL_W-1:0]          in_ctrl,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [CTRL_W-1:0]          out_ctrl,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [CTRL_W-1:0] ctrl_q [DEPTH];
    logic [CTRL_W-1:0] ctrl_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push;
    logic              pop;
    logic              wr_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_MAX) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // in_ready depends only on registered occupancy: a pop never frees a slot in the same cycle.
    assign in_ready  = (count_q < FULL);
    assign out_valid = (count_q != '0);
    assign out_data  = data_q[rd_ptr_q];
    assign out_ctrl  = out_valid ? ctrl_q[rd_ptr_q] : '0;
    assign count     = count_q;

    assign push  = in_valid && in_ready;
    assign pop   = out_valid && out_ready;
    assign wr_en = push && !flush;

    always_comb begin
        data_d = data_q;
        ctrl_d = ctrl_q;
        if (wr_en) begin
            data_d[wr_ptr_q] = in_data;
            ctrl_d[wr_ptr_q] = in_ctrl;
        end
    end

    // A pop during flush still completes downstream; everything left behind is discarded.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        data_q <= data_d;
        ctrl_q <= ctrl_d;
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf at DEPTH 2, 3 and 1 with a queue scoreboard per instance.
module tb_pipe_stage_buf;

    logic clock;
    logic reset;

    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
    logic [127:0] a_in_data, a_out_data;
    logic [4:0]   a_in_ctrl, a_out_ctrl;
    logic [1:0]   a_count;

    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
    logic [15:0]  b_in_data, b_out_data;
    logic [4:0]   b_in_ctrl, b_out_ctrl;
    logic [1:0]   b_count;

    logic         c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_flush;
    logic [15:0]  c_in_data, c_out_data;
    logic [4:0]   c_in_ctrl, c_out_ctrl;
    logic [0:0]   c_count;

    logic [132:0] qa[$];
    logic [20:0]  qb[$];
    logic [20:0]  qc[$];
    int ma_cnt, mb_cnt, mc_cnt;
    int vectors, miscompares;

    pipe_stage_buf #(.DATA_W(128), .CTRL_W(5), .DEPTH(2)) u_a (
        .clock(clock), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_ctrl(a_in_ctrl),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
        .flush(a_flush), .count(a_count)
    );

    pipe_stage_buf #(.DATA_W(16), .CTRL_W(5), .DEPTH(3)) u_b (
        .clock(clock), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_ctrl(b_in_ctrl),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
        .flush(b_flush), .count(b_count)
    );

    pipe_stage_buf #(.DATA_W(16), .CTRL_W(5), .DEPTH(1)) u_c (
        .clock(clock), .reset(reset),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data), .in_ctrl(c_in_ctrl),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data), .out_ctrl(c_out_ctrl),
        .flush(c_flush), .count(c_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got hang want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            a_in_valid = 1'b0; a_in_ctrl = 5'h1F; a_in_data = {4{$urandom}}; a_out_ready = k[0];
            b_in_ctrl = 5'h1F; c_in_ctrl = 5'h1F;
            @(negedge clock);
            vectors++;
            if ({a_in_ready, a_out_valid, a_count, a_out_ctrl} !== {1'b1, 1'b0, 2'd0, 5'd0}) begin
                miscompares++;
                $display("FAIL reset_a cyc%0d: got rdy=%b vld=%b cnt=%0d ctrl=%h want rdy=1 vld=0 cnt=0 ctrl=00",
                         k, a_in_ready, a_out_valid, a_count, a_out_ctrl);
            end
            if (k == 0) begin
                vectors++;
                if ({b_in_ready, b_out_valid, b_count, b_out_ctrl} !== {1'b1, 1'b0, 2'd0, 5'd0}) begin
                    miscompares++;
                    $display("FAIL reset_b: got rdy=%b vld=%b cnt=%0d ctrl=%h want rdy=1 vld=0 cnt=0 ctrl=00",
                             b_in_ready, b_out_valid, b_count, b_out_ctrl);
                end
                vectors++;
                if ({c_in_ready, c_out_valid, c_count, c_out_ctrl} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
                    miscompares++;
                    $display("FAIL reset_c: got rdy=%b vld=%b cnt=%0d ctrl=%h want rdy=1 vld=0 cnt=0 ctrl=00",
                             c_in_ready, c_out_valid, c_count, c_out_ctrl);
                end
            end
            @(posedge clock); #1;
        end
        a_in_ctrl = '0; b_in_ctrl = '0; c_in_ctrl = '0; a_out_ready = 1'b0;
    endtask

    // One scenario on the DEPTH=2 instance, driven from a per-cycle schedule chosen by 'mode'.
    task automatic run_a(input int mode, input int ncyc, input int want_pops);
        bit exp_rdy, exp_vld, pu, po;
        int pops = 0;
        logic [7:0] items [3];
        int idx = 0;
        items[0] = 8'h0A; items[1] = 8'h0B; items[2] = 8'h0C;
        for (int k = 0; k < ncyc; k++) begin
            a_flush = 1'b0; reset = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
            case (mode)
                0: begin
                    a_in_valid = (k < 8); a_in_data = 128'(k + 1); a_out_ready = 1'b1;
                end
                1: begin
                    a_in_valid = (idx < 3); a_in_data = 128'(items[idx < 3 ? idx : 2]); a_out_ready = (k >= 4);
                end
                2: begin
                    a_in_valid = (k < 3) || (k == 4) || (k == 5);
                    a_in_data = (k == 0) ? 128'h0A : (k == 1) ? 128'h0B : (k == 2) ? 128'h0D :
                                (k == 4) ? 128'h0E : 128'h0F;
                    a_out_ready = (k == 2);
                    a_flush = (k == 2) || (k == 5);
                end
                default: begin
                    a_in_valid = (k < 4);
                    a_in_data = (k == 0) ? 128'h0A : (k == 1) ? 128'h0B : (k == 2) ? 128'h77 : 128'h55;
                    a_out_ready = (k == 4);
                    a_flush = (k == 2);
                    reset = (k == 2);
                end
            endcase
            a_in_ctrl = a_in_data[4:0] ^ 5'h1F;
            @(negedge clock);
            exp_rdy = (ma_cnt < 2);
            exp_vld = (ma_cnt != 0);
            vectors++;
            if ({a_in_ready, a_out_valid, a_count} !== {exp_rdy, exp_vld, 2'(ma_cnt)}) begin
                miscompares++;
                $display("FAIL a_state m%0d cyc%0d: got rdy=%b vld=%b cnt=%0d want rdy=%b vld=%b cnt=%0d",
                         mode, k, a_in_ready, a_out_valid, a_count, exp_rdy, exp_vld, ma_cnt);
            end
            vectors++;
            if (exp_vld && qa.size() != 0) begin
                if ({a_out_ctrl, a_out_data} !== qa[0]) begin
                    miscompares++;
                    $display("FAIL a_data m%0d cyc%0d: got ctrl=%h data=%h want ctrl=%h data=%h",
                             mode, k, a_out_ctrl, a_out_data, qa[0][132:128], qa[0][127:0]);
                end
            end else if (a_out_ctrl !== 5'd0) begin
                miscompares++;
                $display("FAIL a_bubble_ctrl m%0d cyc%0d: got %h want 00", mode, k, a_out_ctrl);
            end
            pu = a_in_valid && exp_rdy && !a_flush && !reset;
            po = exp_vld && a_out_ready && !reset;
            if (po && qa.size() != 0) begin
                void'(qa.pop_front());
                pops++;
            end
            if (reset || a_flush) begin
                qa.delete();
                ma_cnt = 0;
            end else begin
                if (pu) qa.push_back({a_in_ctrl, a_in_data});
                ma_cnt += int'(pu) - int'(po);
            end
            if (mode == 1 && pu) idx++;
            @(posedge clock); #1;
        end
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_flush = 1'b0; reset = 1'b0;
        vectors++;
        if (pops != want_pops || qa.size() != 0) begin
            miscompares++;
            $display("FAIL a_drain m%0d: got pops=%0d left=%0d want pops=%0d left=0",
                     mode, pops, qa.size(), want_pops);
        end
    endtask

    task automatic test_streaming();    run_a(0, 11, 8); endtask
    task automatic test_backpressure(); run_a(1, 10, 3); endtask
    task automatic test_flush();        run_a(2, 8, 1);  endtask
    task automatic test_reset_mid();    run_a(3, 7, 1);  endtask

    task automatic test_wrap_depth3();
        bit exp_rdy, exp_vld, pu, po;
        int pops = 0;
        int idx = 0;
        for (int k = 0; k < 60 && pops < 10; k++) begin
            b_flush = 1'b0;
            b_in_valid = (idx < 10); b_in_data = 16'hB0 + 16'(idx); b_in_ctrl = 5'(idx) ^ 5'h15;
            b_out_ready = (k >= 4) && (k % 3 != 0);
            @(negedge clock);
            exp_rdy = (mb_cnt < 3);
            exp_vld = (mb_cnt != 0);
            vectors++;
            if ({b_in_ready, b_out_valid, b_count} !== {exp_rdy, exp_vld, 2'(mb_cnt)}) begin
                miscompares++;
                $display("FAIL b_state cyc%0d: got rdy=%b vld=%b cnt=%0d want rdy=%b vld=%b cnt=%0d",
                         k, b_in_ready, b_out_valid, b_count, exp_rdy, exp_vld, mb_cnt);
            end
            vectors++;
            if (exp_vld && qb.size() != 0) begin
                if ({b_out_ctrl, b_out_data} !== qb[0]) begin
                    miscompares++;
                    $display("FAIL b_data cyc%0d: got ctrl=%h data=%h want ctrl=%h data=%h",
                             k, b_out_ctrl, b_out_data, qb[0][20:16], qb[0][15:0]);
                end
            end else if (b_out_ctrl !== 5'd0) begin
                miscompares++;
                $display("FAIL b_bubble_ctrl cyc%0d: got %h want 00", k, b_out_ctrl);
            end
            pu = b_in_valid && exp_rdy;
            po = exp_vld && b_out_ready;
            if (po && qb.size() != 0) begin
                void'(qb.pop_front());
                pops++;
            end
            if (pu) begin
                qb.push_back({b_in_ctrl, b_in_data});
                idx++;
            end
            mb_cnt += int'(pu) - int'(po);
            @(posedge clock); #1;
        end
        b_in_valid = 1'b0; b_out_ready = 1'b0;
        vectors++;
        if (pops != 10 || qb.size() != 0) begin
            miscompares++;
            $display("FAIL b_drain: got pops=%0d left=%0d want pops=10 left=0", pops, qb.size());
        end
    endtask

    task automatic test_depth1();
        bit exp_rdy, exp_vld, pu, po;
        int pops = 0;
        int idx = 0;
        int last_pop = -1;
        for (int k = 0; k < 20 && pops < 6; k++) begin
            c_flush = 1'b0;
            c_in_valid = (idx < 6); c_in_data = 16'hC0 + 16'(idx); c_in_ctrl = 5'(idx) | 5'h10;
            c_out_ready = 1'b1;
            @(negedge clock);
            exp_rdy = (mc_cnt < 1);
            exp_vld = (mc_cnt != 0);
            vectors++;
            if ({c_in_ready, c_out_valid, c_count} !== {exp_rdy, exp_vld, 1'(mc_cnt)}) begin
                miscompares++;
                $display("FAIL c_state cyc%0d: got rdy=%b vld=%b cnt=%0d want rdy=%b vld=%b cnt=%0d",
                         k, c_in_ready, c_out_valid, c_count, exp_rdy, exp_vld, mc_cnt);
            end
            vectors++;
            if (exp_vld && qc.size() != 0) begin
                if ({c_out_ctrl, c_out_data} !== qc[0]) begin
                    miscompares++;
                    $display("FAIL c_data cyc%0d: got ctrl=%h data=%h want ctrl=%h data=%h",
                             k, c_out_ctrl, c_out_data, qc[0][20:16], qc[0][15:0]);
                end
            end else if (c_out_ctrl !== 5'd0) begin
                miscompares++;
                $display("FAIL c_bubble_ctrl cyc%0d: got %h want 00", k, c_out_ctrl);
            end
            pu = c_in_valid && exp_rdy;
            po = exp_vld && c_out_ready;
            if (po && qc.size() != 0) begin
                void'(qc.pop_front());
                pops++;
                last_pop = k;
            end
            if (pu) begin
                qc.push_back({c_in_ctrl, c_in_data});
                idx++;
            end
            mc_cnt += int'(pu) - int'(po);
            @(posedge clock); #1;
        end
        c_in_valid = 1'b0; c_out_ready = 1'b0;
        vectors++;
        if (pops != 6 || last_pop != 11) begin
            miscompares++;
            $display("FAIL c_rate: got pops=%0d last_pop_cyc=%0d want pops=6 last_pop_cyc=11", pops, last_pop);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        ma_cnt = 0; mb_cnt = 0; mc_cnt = 0;
        reset = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0; a_in_ctrl = '0; a_out_ready = 1'b0; a_flush = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_ctrl = '0; b_out_ready = 1'b0; b_flush = 1'b0;
        c_in_valid = 1'b0; c_in_data = '0; c_in_ctrl = '0; c_out_ready = 1'b0; c_flush = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_wrap_depth3();
        test_depth1();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
